// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Purpose
//   Generates 640x480@60Hz VGA timing from the 100 MHz board clock. A clock
//   divider produces one pixel slot every CLK_DIV system clocks. Horizontal and
//   vertical counters walk the full raster, including the blanking intervals.
//   The module emits the pixel coordinates, the blanking flag, both sync pins
//   and a once-per-frame strobe that game logic can use as its update tick.
//
// Ports
//   clk         in   1   system clock (100 MHz)
//   reset       in   1   synchronous reset, active low (asserted when 0)
//   hsync       out  1   horizontal sync, registered, active level SYNC_POL
//   vsync       out  1   vertical sync, registered, active level SYNC_POL
//   video_on    out  1   high while (x < H_DISP) && (y < V_DISP)
//   p_tick      out  1   one-clk strobe in the last clk of each pixel slot
//   x           out  10  current pixel column, 0..H_TOTAL-1
//   y           out  10  current line, 0..V_TOTAL-1
//   frame_tick  out  1   one-clk strobe in the first clk of pixel (0, FRAME_LINE)
//
// Timing notes
//   All outputs are flops. The sync, blanking and strobe flags are decoded from
//   the *next* counter values (the _d side), so they change on the same edge as
//   x/y. A downstream stage therefore never sees the flags and the coordinates
//   disagree, and there is no combinational path from counters to pins.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV    = 4,    // clk cycles per pixel, must be >= 2
  parameter int H_DISP     = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_DISP     = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,    // 0 = active-low sync pulses
  parameter int FRAME_LINE = 481
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_tick
);

  // ---------------------------------------------------------------------------
  // Derived geometry. Everything compared against the 10-bit counters is cast
  // to 10 bits once here so the decode logic below stays width-clean.
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_DISP   = 10'(H_DISP);
  localparam logic [9:0] Y_DISP   = 10'(V_DISP);
  localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic [9:0] FRAME_Y  = 10'(FRAME_LINE);

  localparam logic SYNC_ACT  = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = ~SYNC_ACT;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             p_tick_q, p_tick_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_tick_q, frame_tick_d;

  // True during the last clk of a pixel slot; the counters step on the edge
  // that ends this clk.
  logic             advance;
  logic             x_wrap;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    advance = (div_q == DIV_LAST);
    x_wrap  = advance && (x_q == X_LAST);

    // Pixel-rate divider. Wrapped explicitly so non-power-of-two CLK_DIV works.
    div_d = advance ? '0 : div_q + 1'b1;

    // Raster counters. y only moves when x wraps, so both wrap on one edge at
    // the bottom-right corner.
    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // p_tick marks the clk in which div sits at its last count, so it is
    // decoded from the divider value that will be loaded on this edge.
    p_tick_d = (div_d == DIV_LAST);

    // Sync and blanking decodes from the values x/y take on this edge.
    hsync_d    = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_ACT : SYNC_IDLE;
    vsync_d    = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_ACT : SYNC_IDLE;
    video_on_d = (x_d < X_DISP) && (y_d < Y_DISP);

    // Fires only on the edge that enters (0, FRAME_LINE). Gating with advance
    // keeps it to the first clk of that pixel rather than all CLK_DIV clks.
    frame_tick_d = advance && (x_d == 10'd0) && (y_d == FRAME_Y);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      p_tick_q     <= 1'b0;
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      x_q          <= x_d;
      y_q          <= y_d;
      p_tick_q     <= p_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign x          = x_q;
  assign y          = y_q;
  assign p_tick     = p_tick_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = frame_tick_q;

endmodule
